// File: rtl/vga_raster_wr_arbiter.sv
// Round-robin write arbiter in front of the VGA raster's tile/sprite slave, with bounded lock.
// Optional VGA_ARB_VBLANK_LOCK_EN restricts requester 1 to the vertical blanking interval.
module vga_raster_wr_arbiter #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_write,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_write,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_writedata,
  output logic              s_write,
  input  logic              s_waitrequest,
  input  logic              vblank,
  output logic              busy,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_SAT    = '1;

  logic [1:0]        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic              busy_q;
  logic              m0_elig, m1_elig, m1_may_lock;

`ifdef VGA_ARB_VBLANK_LOCK_EN
  // Requester 1 only starts inside vblank and never chains beats with lock.
  logic unused_m1_lock;
  assign unused_m1_lock = m1_lock;
  assign m1_elig        = m1_write & vblank;
  assign m1_may_lock    = 1'b0;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign m1_elig       = m1_write;
  assign m1_may_lock   = m1_lock;
`endif

  assign m0_elig  = m0_write;
  assign hold_inc = hold_q + 1'b1;

  always_comb begin
    s_address      = '0;
    s_writedata    = '0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      GRANT0: begin
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_write        = m0_write;
        m0_waitrequest = s_waitrequest;
      end
      GRANT1: begin
        s_address      = m1_address;
        s_writedata    = m1_writedata;
        s_write        = m1_write;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    hold_d    = hold_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (m0_elig && m1_elig) begin
          state_d = rr_last_q ? GRANT0 : GRANT1;
        end else if (m0_elig) begin
          state_d = GRANT0;
        end else if (m1_elig) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (!m0_write) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (!s_waitrequest) begin
          if (cnt0_q != CNT_SAT) cnt0_d = cnt0_q + 1'b1;
          rr_last_d = 1'b0;
          // With nobody waiting the hold counter wraps, so the lock is unbounded.
          if (m0_lock && (!m1_elig || hold_inc < HOLD_LIMIT)) begin
            hold_d = (hold_inc == HOLD_LIMIT) ? '0 : hold_inc;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end
      end
      GRANT1: begin
        if (!m1_write) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (!s_waitrequest) begin
          if (cnt1_q != CNT_SAT) cnt1_d = cnt1_q + 1'b1;
          rr_last_d = 1'b1;
          if (m1_may_lock && (!m0_elig || hold_inc < HOLD_LIMIT)) begin
            hold_d = (hold_inc == HOLD_LIMIT) ? '0 : hold_inc;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      hold_q    <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      hold_q    <= hold_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign busy       = busy_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_vga_raster_wr_arbiter.sv
// Bench for vga_raster_wr_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_vga_raster_wr_arbiter;

  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
`ifdef VGA_ARB_VBLANK_LOCK_EN
  localparam bit VB_MODE = 1'b1;
`else
  localparam bit VB_MODE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic              m0_write, m0_lock, m0_waitrequest;
  logic              m1_write, m1_lock, m1_waitrequest;
  logic              s_write, s_waitrequest, vblank, busy;
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

  always #5 clk = ~clk;

  vga_raster_wr_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_HOLD(MAX_HOLD),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m0_address    (m0_address),
    .m0_writedata  (m0_writedata),
    .m0_write      (m0_write),
    .m0_lock       (m0_lock),
    .m0_waitrequest(m0_waitrequest),
    .m1_address    (m1_address),
    .m1_writedata  (m1_writedata),
    .m1_write      (m1_write),
    .m1_lock       (m1_lock),
    .m1_waitrequest(m1_waitrequest),
    .s_address     (s_address),
    .s_writedata   (s_writedata),
    .s_write       (s_write),
    .s_waitrequest (s_waitrequest),
    .vblank        (vblank),
    .busy          (busy),
    .grant_cnt0    (grant_cnt0),
    .grant_cnt1    (grant_cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: owner 0 = nobody, 1 = requester 0, 2 = requester 1.
  int owner, run, c0, c1;
  bit last_winner;
  bit acc0, acc1;

  task automatic model_reset();
    owner = 0; run = 0; c0 = 0; c1 = 0; last_winner = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
  endtask

  task automatic check_outputs();
    logic [31:0] e_sw, e_sa, e_sd, e_w0, e_w1;
    e_sw = 0; e_sa = 0; e_sd = 0; e_w0 = 1; e_w1 = 1;
    if (owner == 1) begin
      e_sw = 32'(m0_write); e_sa = 32'(m0_address); e_sd = 32'(m0_writedata);
      e_w0 = 32'(s_waitrequest);
    end else if (owner == 2) begin
      e_sw = 32'(m1_write); e_sa = 32'(m1_address); e_sd = 32'(m1_writedata);
      e_w1 = 32'(s_waitrequest);
    end
    check("s_write", 32'(s_write), e_sw);
    check("s_address", 32'(s_address), e_sa);
    check("s_writedata", 32'(s_writedata), e_sd);
    check("m0_waitrequest", 32'(m0_waitrequest), e_w0);
    check("m1_waitrequest", 32'(m1_waitrequest), e_w1);
    check("busy", 32'(busy), 32'(owner != 0));
    check("grant_cnt0", 32'(grant_cnt0), 32'(c0));
    check("grant_cnt1", 32'(grant_cnt1), 32'(c1));
  endtask

  task automatic model_step();
    bit want0, want1, wr, other_waiting, may_lock;
    acc0 = 1'b0; acc1 = 1'b0;
    want0 = m0_write;
    want1 = m1_write && (!VB_MODE || vblank);
    if (reset) begin
      model_reset();
    end else if (owner == 0) begin
      if (want0 && want1) owner = last_winner ? 1 : 2;
      else if (want0) owner = 1;
      else if (want1) owner = 2;
    end else begin
      wr = (owner == 1) ? m0_write : m1_write;
      if (!wr) begin
        owner = 0; run = 0;
      end else if (!s_waitrequest) begin
        if (owner == 1) begin
          acc0 = 1'b1; last_winner = 1'b0; if (c0 < CNT_MAX) c0++;
          other_waiting = want1; may_lock = m0_lock;
        end else begin
          acc1 = 1'b1; last_winner = 1'b1; if (c1 < CNT_MAX) c1++;
          other_waiting = want0; may_lock = m1_lock && !VB_MODE;
        end
        run++;
        if (may_lock && (!other_waiting || run < int'(MAX_HOLD))) begin
          if (run >= int'(MAX_HOLD)) run = 0;
        end else begin
          owner = 0; run = 0;
        end
      end
    end
  endtask

  // Called at a falling edge: check, advance the model, move to the next falling edge.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_random();
    if (!(m0_write && !acc0)) begin
      m0_write = ($urandom % 4) != 0;
      m0_address = ADDR_W'($urandom); m0_writedata = DATA_W'($urandom);
      m0_lock = 1'($urandom);
    end
    if (!(m1_write && !acc1)) begin
      m1_write = ($urandom % 4) != 0;
      m1_address = ADDR_W'($urandom); m1_writedata = DATA_W'($urandom);
      m1_lock = 1'($urandom);
    end
    s_waitrequest = ($urandom % 4) == 0;
    if (($urandom % 16) == 0) vblank = ~vblank;
    reset = ($urandom % 400) == 0;
  endtask

  task automatic idle_inputs();
    m0_write = 0; m0_lock = 0; m0_address = '0; m0_writedata = '0;
    m1_write = 0; m1_lock = 0; m1_address = '0; m1_writedata = '0;
    s_waitrequest = 0; vblank = 1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int who[4];
  int at[4];
  int nb;

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    apply_reset();

    // Single m0 write: slave sees it on the second cycle.
    m0_write = 1; m0_address = 9'h010; m0_writedata = 16'hBEEF;
    tick();
    check("t1_s_write", 32'(s_write), 1);
    check("t1_m0_wait", 32'(m0_waitrequest), 0);
    check("t1_addr", 32'(s_address), 32'h010);
    tick();
    m0_write = 0;
    check("t1_cnt0", 32'(grant_cnt0), 1);
    check("t1_idle", 32'(busy), 0);
    tick();

    // Both write together, no lock: alternate with an IDLE gap.
    idle_inputs();
    apply_reset();
    m0_write = 1; m1_write = 1; m0_address = 9'h001; m1_address = 9'h002;
    nb = 0;
    for (int cyc = 0; cyc < 20 && nb < 4; cyc++) begin
      if (s_write) begin
        who[nb] = m0_waitrequest ? 1 : 0;
        at[nb] = cyc;
        nb++;
      end
      tick();
    end
    check("t2_beats", 32'(nb), 4);
    for (int i = 0; i < 4; i++) check("t2_order", 32'(who[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++) check("t2_gap", 32'(at[i] - at[i-1]), 2);
    check("t2_cnt0", 32'(grant_cnt0), 2);
    check("t2_cnt1", 32'(grant_cnt1), 2);

    // m0 locked with m1 waiting: m0 gets exactly MAX_HOLD beats first.
    idle_inputs();
    apply_reset();
    m0_write = 1; m0_lock = 1; m1_write = 1;
    for (int cyc = 0; cyc < 40 && grant_cnt1 == 0; cyc++) tick();
    check("t3_m1_granted", 32'(grant_cnt1), 1);
    check("t3_m0_run", 32'(grant_cnt0), MAX_HOLD);

    // Reset during a stalled GRANT0 beat.
    idle_inputs();
    apply_reset();
    m0_write = 1; s_waitrequest = 1;
    tick();
    tick();
    check("t5_stalled", 32'(busy), 1);
    reset = 1;
    tick();
    check("t5_s_write", 32'(s_write), 0);
    check("t5_m0_wait", 32'(m0_waitrequest), 1);
    check("t5_m1_wait", 32'(m1_waitrequest), 1);
    check("t5_cnt0", 32'(grant_cnt0), 0);
    check("t5_busy", 32'(busy), 0);
    reset = 0;

    // m1 waits out a non-blanking period.
    idle_inputs();
    apply_reset();
    m1_write = 1; vblank = 0; s_waitrequest = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t6_pre_vblank", 32'(busy), 32'(!VB_MODE));
      tick();
    end
    vblank = 1;
    tick();
    check("t6_post_vblank", 32'(busy), 1);

    idle_inputs();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
